fft_out_unloader: RTL and testbench
===================================

Name: fft_out_unloader

Overview:
- Drains one completed N-point FFT frame from the dual-port result memory and streams it out on the core's output push/stall interface.
- Reads the memory in bit-reversed order, so samples leave in natural frequency order, bin 0 first.
- Sits between the result memory read port and the core's out_push_F/out_real_F/out_imag_F/out_stall pins.
- Returns the frame buffer to the FFT controller when the frame has fully drained.

Parameters:
- NBITS, 16, width of each real/imag component.
- LOG2N, 4, log2 of the FFT size (N = 16 = memory depth).
- BITREV, 1, 1 = read address is the bit-reversed sample counter; 0 = linear address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- frame_ready  input  1  level from the controller; memory holds a complete transformed frame.
- frame_done  output  1  one-cycle pulse; frame fully delivered, memory may be reloaded.
- rd_en  output  1  memory read strobe.
- rd_addr  output  LOG2N  memory read address.
- rd_data  input  2*NBITS  {real[2*NBITS-1:NBITS], imag[NBITS-1:0]}; valid exactly 1 cycle after an rd_en.
- out_push_F  output  1  registered output-valid.
- out_real_F  output  NBITS  registered sample, real part.
- out_imag_F  output  NBITS  registered sample, imag part.
- out_stall  input  1  downstream cannot accept this cycle.

Behaviour:
- Transfer rule: a sample transfers on a rising edge where out_push_F=1 and out_stall=0. While out_stall=1, out_push_F/out_real_F/out_imag_F hold their values.
- Reset values, asynchronous on reset=0:
  - state=IDLE; rd_cnt=0; out_cnt=0; skid buffer empty.
  - out_push_F=0, out_real_F=0, out_imag_F=0.
  - rd_en=0, rd_addr=0, frame_done=0.
  - Reset mid-frame abandons the frame; no partial frame_done is issued.
- State IDLE: outputs idle. frame_ready=1 moves to STREAM next cycle and clears rd_cnt and out_cnt.
- State STREAM:
  - Issue rd_en=1 when rd_cnt<N and (skid occupancy + reads in flight + output-register occupancy not transferring this cycle) < 3.
  - rd_addr = bitrev(rd_cnt) if BITREV, else rd_cnt. rd_cnt increments per read.
  - Returned data enters a 2-entry skid FIFO, or bypasses it straight to the output register when the FIFO is empty and the output register is free or transferring.
  - The output register loads when it is empty or is transferring.
  - out_cnt increments on each transfer. When the transfer with out_cnt=N-1 occurs, go to DONE.
- State DONE: frame_done=1 for exactly one cycle, then IDLE. If frame_ready is still 1 in IDLE, a new frame starts, so back-to-back frames are allowed.
- Latency and throughput:
  - frame_ready rising at edge k: rd_en at cycle k+1, data at k+2, first out_push_F=1 at k+3.
  - With out_stall=0 throughout: one sample per cycle, 16 consecutive pushes at k+3..k+18, frame_done at k+19.
- No sample is lost or duplicated under any out_stall pattern, including a stall asserted in the same cycle a read returns. A full skid FIFO blocks rd_en.
- frame_ready dropping during STREAM is ignored; the frame completes.
- rd_cnt stops at N. No read address beyond N-1 is issued, and no wrap-around occurs within a frame.

Optional Feature:
- Macro FFT_OUT_SCALE_EN.
- When defined: each component is arithmetically right-shifted by LOG2N with round-half-up (add 1<<(LOG2N-1) before the shift), then saturated to the signed NBITS range. Scaling is applied combinationally ahead of the output register, so latency is unchanged.
- When not defined: components pass through bit-exact.

Test Plan:
- Memory preloaded addr i = {i, -i}, BITREV=1, out_stall=0, frame_ready pulse → 16 pushes starting 3 cycles later, sample j = {bitrev4(j), -bitrev4(j)}: order 0,8,4,12,2,...,15; frame_done one cycle after the last push.
- Same frame with out_stall high on cycles 5–9 and on every odd cycle afterwards → identical 16-sample sequence, no duplicates or gaps; rd_en never issues while the skid FIFO is full.
- BITREV=0, memory addr i = {100+i, 0} → outputs 100..115 in order.
- reset driven low after 7 transfers, then released → all outputs 0, no frame_done; the next frame_ready restarts from sample 0.
- frame_ready held high across two frames with memory rewritten between them → frame_done pulses twice, 32 pushes total, second frame restarts at sample 0.
- FFT_OUT_SCALE_EN defined, inputs {0x7FFF, 0x8000} and {24, -24} → outputs {0x0800, 0xF800} and {2, -1}; 24 gives (24+8)>>4 = 2 and -24 gives (-24+8)>>4 = -1. Without the macro the values pass unchanged.

Source files
------------

// File: rtl/fft_out_unloader.sv
`timescale 1ns/1ps
// Drains one N-point FFT frame from the result memory in bit-reversed address order; frame_ready to first push is 3 cycles, 1 sample/clk.
// out_stall freezes the output register; a 2-entry skid absorbs in-flight reads. FFT_OUT_SCALE_EN adds rounded >>LOG2N with saturation.
module fft_out_unloader #(
  parameter int NBITS  = 16,
  parameter int LOG2N  = 4,
  parameter int BITREV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_ready,
  output logic               frame_done,
  output logic               rd_en,
  output logic [LOG2N-1:0]   rd_addr,
  input  logic [2*NBITS-1:0] rd_data,
  output logic               out_push_F,
  output logic [NBITS-1:0]   out_real_F,
  output logic [NBITS-1:0]   out_imag_F,
  input  logic               out_stall
);

  localparam logic [LOG2N:0]   N_CNT    = (LOG2N+1)'(1 << LOG2N);
  localparam logic [LOG2N:0]   RD_ONE   = (LOG2N+1)'(1);
  localparam logic [LOG2N-1:0] OUT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LOG2N:0]     rd_cnt_q, rd_cnt_d;
  logic [LOG2N-1:0]   out_cnt_q, out_cnt_d;
  logic               rd_en_q, rd_en_d;
  logic [LOG2N-1:0]   rd_addr_q, rd_addr_d;
  logic               rd_vld_q, rd_vld_d;
  logic [2*NBITS-1:0] skid_q [2];
  logic [2*NBITS-1:0] skid_d [2];
  logic               skid_wp_q, skid_wp_d;
  logic               skid_rp_q, skid_rp_d;
  logic [1:0]         skid_cnt_q, skid_cnt_d;
  logic               out_push_q, out_push_d;
  logic [NBITS-1:0]   out_real_q, out_real_d;
  logic [NBITS-1:0]   out_imag_q, out_imag_d;

  logic               xfer, out_free, out_load, skid_push, skid_pop, issue;
  logic [2:0]         budget;
  logic [2*NBITS-1:0] load_dat;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

`ifdef FFT_OUT_SCALE_EN
  localparam int                  RND_I = 1 << (LOG2N-1);
  localparam logic signed [NBITS:0] RND  = (NBITS+1)'(RND_I);
  localparam logic signed [NBITS:0] SMAX = (NBITS+1)'((1 << (NBITS-1)) - 1);
  localparam logic signed [NBITS:0] SMIN = (NBITS+1)'(-(1 << (NBITS-1)));

  // One guard bit keeps the rounding add from wrapping before the shift.
  function automatic logic [NBITS-1:0] comp_out(input logic [NBITS-1:0] x);
    logic signed [NBITS:0] v;
    v = ($signed({x[NBITS-1], x}) + RND) >>> LOG2N;
    if (v > SMAX) v = SMAX;
    else if (v < SMIN) v = SMIN;
    return v[NBITS-1:0];
  endfunction
`else
  function automatic logic [NBITS-1:0] comp_out(input logic [NBITS-1:0] x);
    return x;
  endfunction
`endif

  always_comb begin
    xfer      = out_push_q & ~out_stall;
    out_free  = ~out_push_q | xfer;
    // Count every slot already promised: skid entries, both read pipeline stages, and a held output.
    budget    = {1'b0, skid_cnt_q} + {2'b00, rd_en_q} + {2'b00, rd_vld_q} + {2'b00, out_push_q & out_stall};
    issue     = (state_q == S_STREAM) && (rd_cnt_q < N_CNT) && (budget < 3'd3);
    skid_pop  = out_free && (skid_cnt_q != 2'd0);
    out_load  = out_free && ((skid_cnt_q != 2'd0) || rd_vld_q);
    skid_push = rd_vld_q && !((skid_cnt_q == 2'd0) && out_free);
    load_dat  = (skid_cnt_q != 2'd0) ? skid_q[skid_rp_q] : rd_data;

    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    rd_en_d    = issue;
    rd_vld_d   = rd_en_q;
    rd_addr_d  = rd_addr_q;
    skid_d     = skid_q;
    skid_wp_d  = skid_wp_q;
    skid_rp_d  = skid_rp_q;
    skid_cnt_d = skid_cnt_q;
    out_push_d = out_push_q;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;

    if (issue) begin
      rd_addr_d = (BITREV != 0) ? bit_rev(rd_cnt_q[LOG2N-1:0]) : rd_cnt_q[LOG2N-1:0];
      rd_cnt_d  = rd_cnt_q + RD_ONE;
    end

    if (skid_push) begin
      skid_d[skid_wp_q] = rd_data;
      skid_wp_d         = ~skid_wp_q;
    end
    if (skid_pop) skid_rp_d = ~skid_rp_q;
    case ({skid_push, skid_pop})
      2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
      2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
      default: skid_cnt_d = skid_cnt_q;
    endcase

    if (out_free) begin
      out_push_d = out_load;
      if (out_load) begin
        out_real_d = comp_out(load_dat[2*NBITS-1:NBITS]);
        out_imag_d = comp_out(load_dat[NBITS-1:0]);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (frame_ready) begin
          state_d   = S_STREAM;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          out_cnt_d = out_cnt_q + OUT_ONE;
          if (out_cnt_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      skid_wp_q  <= 1'b0;
      skid_rp_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      out_push_q <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_vld_q   <= rd_vld_d;
      skid_wp_q  <= skid_wp_d;
      skid_rp_q  <= skid_rp_d;
      skid_cnt_q <= skid_cnt_d;
      out_push_q <= out_push_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign frame_done = (state_q == S_DONE);
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign out_push_F = out_push_q;
  assign out_real_F = out_real_q;
  assign out_imag_F = out_imag_q;

endmodule

// File: tb/tb_fft_out_unloader.sv
`timescale 1ns/1ps
// Bench for fft_out_unloader: a bit-reversed and a linear instance share stall/frame_ready stimulus and
// are checked against a frame-level model (expected bin order, read budget, frame_done timing).
module tb_fft_out_unloader;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, frame_ready, out_stall;
  logic [1:0]       frame_done, rd_en, out_push_F;
  logic [1:0][3:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0][15:0] out_real, out_imag;
  logic [31:0]      mem [2][N];

  fft_out_unloader #(.NBITS(16), .LOG2N(4), .BITREV(1)) u_dut_br (
    .clk(clk), .reset(reset), .frame_ready(frame_ready), .frame_done(frame_done[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .out_push_F(out_push_F[0]), .out_real_F(out_real[0]), .out_imag_F(out_imag[0]),
    .out_stall(out_stall));

  fft_out_unloader #(.NBITS(16), .LOG2N(4), .BITREV(0)) u_dut_lin (
    .clk(clk), .reset(reset), .frame_ready(frame_ready), .frame_done(frame_done[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .out_push_F(out_push_F[1]), .out_real_F(out_real[1]), .out_imag_F(out_imag[1]),
    .out_stall(out_stall));

  // Result memory: one-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) rd_data[g] <= rd_en[g] ? mem[g][rd_addr[g]] : $urandom;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state, per instance
  int          m_cnt[2], rd_model[2], captured[2], xfers[2], done_cnt[2], push_cnt[2];
  logic        rd_p1[2], rd_p2[2], done_due[2], hold_due[2];
  logic [31:0] prev_dat[2];

  function automatic int bitrev4(input int j);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if ((j & (1 << i)) != 0) r += (8 >> i);
    return r;
  endfunction

  function automatic int addr_of(input int g, input int j);
    return (g == 0) ? bitrev4(j & 15) : (j & 15);
  endfunction

  function automatic logic [15:0] exp_comp(input logic [15:0] x);
`ifdef FFT_OUT_SCALE_EN
    int v;
    v = (int'($signed(x)) + 8) >>> 4;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] exp_sample(input int g, input int j);
    logic [31:0] d;
    d = mem[g][addr_of(g, j)];
    return {exp_comp(d[31:16]), exp_comp(d[15:0])};
  endfunction

  task automatic reset_model();
    for (int g = 0; g < 2; g++) begin
      m_cnt[g] = 0; rd_model[g] = 0; captured[g] = 0; xfers[g] = 0;
      rd_p1[g] = 1'b0; rd_p2[g] = 1'b0; done_due[g] = 1'b0; hold_due[g] = 1'b0;
      prev_dat[g] = '0;
    end
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin
          mem[0][i] = {16'(i), 16'(-i)};
          mem[1][i] = {16'(100 + i), 16'h0000};
        end
        1: begin
          mem[0][i] = $urandom;
          mem[1][i] = $urandom;
        end
        default: begin
          mem[0][i] = $urandom;
          mem[1][i] = $urandom;
          if (i == 0 || i == 5) begin mem[0][i] = 32'h7FFF_8000; mem[1][i] = 32'h7FFF_8000; end
          if (i == 1 || i == 10) begin mem[0][i] = {16'd24, 16'hFFE8}; mem[1][i] = {16'd24, 16'hFFE8}; end
          if (i == 3) begin mem[0][i] = 32'h8000_7FFF; mem[1][i] = 32'h8000_7FFF; end
        end
      endcase
    end
  endtask

  // Called once per falling edge, after the inputs for the next rising edge are set.
  task automatic monitor();
    for (int g = 0; g < 2; g++) begin
      int   skid;
      logic nd;
      captured[g] += int'(rd_p2[g]);
      chk("frame_done", frame_done[g], done_due[g]);
      if (frame_done[g]) begin
        rd_model[g] = 0;
        done_cnt[g]++;
      end
      if (hold_due[g]) chk("stall_hold", {out_push_F[g], out_real[g], out_imag[g]}, {1'b1, prev_dat[g]});
      skid = captured[g] - xfers[g] - int'(out_push_F[g]);
      chk("skid_occ", (skid >= 0 && skid <= 2), 1'b1);
      if (rd_en[g]) begin
        chk("rd_skid_full", (skid < 2), 1'b1);
        chk("rd_overrun", (rd_model[g] < N), 1'b1);
        chk("rd_addr", rd_addr[g], addr_of(g, rd_model[g]));
        rd_model[g]++;
      end
      nd = 1'b0;
      if (out_push_F[g] && !out_stall) begin
        chk("sample", {out_real[g], out_imag[g]}, exp_sample(g, m_cnt[g]));
        xfers[g]++;
        push_cnt[g]++;
        m_cnt[g]++;
        if (m_cnt[g] == N) begin
          m_cnt[g] = 0;
          nd = 1'b1;
        end
      end
      done_due[g] = nd;
      hold_due[g] = out_push_F[g] & out_stall;
      prev_dat[g] = {out_real[g], out_imag[g]};
      rd_p2[g]    = rd_p1[g];
      rd_p1[g]    = rd_en[g];
    end
  endtask

  task automatic step(input logic fr, input logic st);
    @(negedge clk);
    frame_ready = fr;
    out_stall   = st;
    monitor();
  endtask

  task automatic chk_reset_outputs();
    for (int g = 0; g < 2; g++) begin
      chk("rst_push", out_push_F[g], 1'b0);
      chk("rst_real", out_real[g], 16'h0);
      chk("rst_imag", out_imag[g], 16'h0);
      chk("rst_rd_en", rd_en[g], 1'b0);
      chk("rst_rd_addr", rd_addr[g], 4'h0);
      chk("rst_done", frame_done[g], 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; frame_ready = 1'b0; out_stall = 1'b0;
    #1;
    chk_reset_outputs();
    reset_model();
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b1;
  endtask

  // mode 0: no stall, 1: stall on cycles 5..9 then every odd cycle, 2: random stall
  task automatic run_frames(input int nfr, input int mode, input bit hold, input bit refill,
                            output int first_c, output int done_c);
    int   start;
    logic st;
    start = done_cnt[0]; first_c = -1; done_c = -1;
    for (int c = 0; c < 400 * nfr; c++) begin
      case (mode)
        0:       st = 1'b0;
        1:       st = (c >= 5 && c <= 9) || (c > 9 && (c % 2) == 1);
        default: st = ($urandom_range(0, 99) < 40);
      endcase
      step(hold ? 1'b1 : (c == 0), st);
      if (out_push_F[0] && first_c < 0) first_c = c;
      if (frame_done[0]) begin
        if (done_c < 0) done_c = c;
        if (refill) fill_mem(2);
      end
      if (done_cnt[0] - start >= nfr) break;
    end
    chk("frames_done", done_cnt[0] - start, nfr);
  endtask

  task automatic idle_drain();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      chk("idle_push", out_push_F, 2'b00);
      chk("idle_rd", rd_en, 2'b00);
    end
  endtask

  initial begin
    int fc, dc, p0, t;
    reset = 1'b0; frame_ready = 1'b0; out_stall = 1'b0;
    for (int g = 0; g < 2; g++) begin done_cnt[g] = 0; push_cnt[g] = 0; end
    reset_model();
    fill_mem(0);
    #12;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    // Unstalled directed frame: exact latency and one sample per cycle
    p0 = push_cnt[0];
    run_frames(1, 0, 1'b0, 1'b0, fc, dc);
    chk("first_push_lat", fc, 4);
    chk("done_lat", dc, 20);
    chk("frame_pushes", push_cnt[0] - p0, N);
    idle_drain();

    // Same frame under the fixed stall pattern
    p0 = push_cnt[0];
    run_frames(1, 1, 1'b0, 1'b0, fc, dc);
    chk("stall_pushes", push_cnt[0] - p0, N);
    idle_drain();

    // Random data and random stall
    for (int f = 0; f < 6; f++) begin
      fill_mem((f % 2) + 1);
      run_frames(1, 2, 1'b0, 1'b0, fc, dc);
      idle_drain();
    end

    // Reset after 7 transfers abandons the frame
    fill_mem(2);
    step(1'b1, 1'b0);
    t = 0;
    while (m_cnt[0] < 7 && t < 50) begin
      step(1'b0, 1'b0);
      t++;
    end
    chk("mid_frame_reached", m_cnt[0], 7);
    p0 = done_cnt[0];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      chk("post_rst_push", out_push_F, 2'b00);
    end
    chk("no_partial_done", done_cnt[0] - p0, 0);
    run_frames(1, 2, 1'b0, 1'b0, fc, dc);
    idle_drain();

    // frame_ready held across two frames, memory rewritten between them
    fill_mem(1);
    p0 = push_cnt[0];
    run_frames(2, 0, 1'b1, 1'b1, fc, dc);
    chk("b2b_pushes", push_cnt[0] - p0, 2 * N);
    idle_drain();

    p0 = push_cnt[0];
    run_frames(2, 2, 1'b1, 1'b1, fc, dc);
    chk("b2b_rand_pushes", push_cnt[0] - p0, 2 * N);
    idle_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
